calc_result_bcd: RTL and testbench
==================================

# calc_result_bcd

Sequential binary-to-BCD converter that sits directly downstream of the combinational calculator core. It captures the core's 16-bit `result` and its `add/sub/mul/div` indicator flags, then converts the result to five BCD digits using shift-add-3 (double dabble), one bit per clock. It also resolves the sign of subtraction results and flags divide-by-zero. The digits feed the display/formatter stage through a valid/ready handshake.

## Interface
- `WIDTH`, 16, binary input width; one shift cycle per bit.
- `DIGITS`, 5, BCD digit count; must satisfy `DIGITS >= ceil(WIDTH*0.30103)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `result` and the flags are valid this cycle.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `result`  in  WIDTH  calculator result.
- `sub_result`  in  1  result comes from subtraction (two's complement).
- `div_result`  in  1  result comes from division.
- `out_valid`  out  1  `bcd`, `neg` and `err` are valid.
- `out_ready`  in  1  consumer accepts the output.
- `bcd`  out  4*DIGITS  packed digits; digit 0 (units) in [3:0].
- `neg`  out  1  value is negative; `bcd` holds the magnitude.
- `err`  out  1  divide-by-zero code was captured.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. A handshake (`in_valid & in_ready`) captures the operand, `neg` and `err`, clears the BCD accumulator and the bit counter, then moves to CONV.
  - CONV: each cycle, every BCD digit ≥5 gets +3, then {bcd, shift} is shifted left by 1. After the cycle with counter = WIDTH-1, move to DONE.
  - DONE: `out_valid`=1. Outputs are held stable until `out_ready`=1, then return to IDLE.
- Capture rules:
  - `sub_result=1` and `result[WIDTH-1]=1`: operand = two's-complement negation of `result`, `neg`=1.
  - Otherwise: operand = `result` (unsigned), `neg`=0.
  - `div_result=1` and `result` = all ones: `err`=1.
- Output overrides:
  - When `err`=1, `bcd` is presented as all 4'hF digits in DONE. Conversion still runs, so timing is unchanged.
  - Multiplication results with bit 15 set (e.g. 65025) are unsigned; only `sub_result` enables sign handling.
- `in_valid` is ignored outside IDLE. There is no queueing and no overwrite.
- `bcd`, `neg` and `err` are registered. They change only on capture or when DONE is entered.

## Timing
- Reset values: `out_valid`=0, `bcd`=0, `neg`=0, `err`=0, state IDLE, so `in_ready`=1 during and after reset.
- Handshake accepted at edge 0 → shifts at edges 1..WIDTH → `out_valid` is high after edge WIDTH. Latency is 16 clocks.
- Output handshake at edge n → IDLE after edge n, so `in_ready`=1 in cycle n+1. The earliest next accept is edge n+1.
- Minimum initiation interval: WIDTH+2 = 18 clocks (with `out_ready` tied high).
- `out_ready` low: DONE persists indefinitely and the outputs do not glitch.
- `rst_n` asserted in any state (including mid-CONV): returns to IDLE immediately (asynchronous) and all outputs go to their reset values. The partial conversion is discarded.
- Counter width: `$clog2(WIDTH)`. It must not wrap before the DONE transition.

## Configuration
- `CALC_BCD_SIGN_EN` defined:
  - Sign resolution as described above.
- `CALC_BCD_SIGN_EN` undefined:
  - `sub_result` is ignored and every `result` is converted as unsigned; `neg` is tied to 0.
  - Divide-by-zero handling (`err`) is unaffected.

## Test plan
- `result`=300 (add) → after 16 clocks `out_valid`=1, `bcd`=20'h00300, `neg`=0, `err`=0.
- `result`=16'hFFFB with `sub_result`=1 → `bcd`=20'h00005, `neg`=1. With the macro undefined → `bcd`=20'h65531, `neg`=0.
- `result`=65025 (mul 255*255) → `bcd`=20'h65025, `neg`=0.
- `result`=16'hFFFF with `div_result`=1 → `err`=1, `bcd`=20'hFFFFF, latency still 16.
- Backpressure: hold `out_ready`=0 for 10 cycles while pulsing `in_valid` with new data → outputs stable, `in_ready`=0, no new capture. Raise `out_ready` → IDLE next cycle.
- Drop `rst_n` on the 8th CONV cycle → `out_valid`=0, `bcd`=0, IDLE. A fresh `result`=1234 then yields 20'h01234 after 16 clocks.

Source files
------------

// File: rtl/calc_result_bcd_if.sv
// Handshake bundle between the calculator core, the BCD converter and the display formatter.
interface calc_result_bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      result;
    logic                  sub_result;
    logic                  div_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  err;

    modport master (
        output in_valid, result, sub_result, div_result, out_ready,
        input  in_ready, out_valid, bcd, neg, err
    );

    modport slave (
        input  in_valid, result, sub_result, div_result, out_ready,
        output in_ready, out_valid, bcd, neg, err
    );
endinterface

// File: rtl/calc_result_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with sign and div-by-zero flags.
// Optional sign resolution for subtraction results is enabled by defining CALC_BCD_SIGN_EN.
module calc_result_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    calc_result_bcd_if.slave     bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [4*DIGITS-1:0]   acc_q, acc_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  neg_q, neg_d;
    logic                  err_q, err_d;

    logic [WIDTH-1:0]      operand;
    logic                  neg_cap;
    logic                  err_cap;
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   acc_shift;

    assign err_cap = bus.div_result & (&bus.result);

`ifdef CALC_BCD_SIGN_EN
    assign neg_cap = bus.sub_result & bus.result[WIDTH-1];
    assign operand = neg_cap ? (~bus.result) + WIDTH'(1) : bus.result;
`else
    // Sign input is intentionally ignored; every result is treated as unsigned.
    assign neg_cap = bus.sub_result & 1'b0;
    assign operand = bus.result;
`endif

    always_comb begin
        adj = acc_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign acc_shift = {adj[4*DIGITS-2:0], shift_q[WIDTH-1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shift_d = operand;
                    acc_d   = '0;
                    cnt_d   = '0;
                    neg_d   = neg_cap;
                    err_d   = err_cap;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d   = acc_shift;
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // The visible digits update only on DONE entry, so they never show partial results.
                    bcd_d   = err_q ? '1 : acc_shift;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.bcd       = bcd_q;
    assign bus.neg       = neg_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_calc_result_bcd.sv
// Directed self-checking bench for calc_result_bcd; expectations follow CALC_BCD_SIGN_EN.
module tb_calc_result_bcd;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    calc_result_bcd_if #(.WIDTH(16), .DIGITS(5)) bus ();

    calc_result_bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge; out_ready is high so DONE lasts one cycle.
    task automatic run(input string tag, input logic [15:0] r, input logic s, input logic d,
                       input logic [19:0] eb, input logic en, input logic ee);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.result     = r;
        bus.sub_result = s;
        bus.div_result = d;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.result     = 16'h0000;
        bus.sub_result = 1'b0;
        bus.div_result = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check({tag, "_valid_early"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_bcd"}, 32'(bus.bcd), 32'(eb));
        check({tag, "_neg"}, 32'(bus.neg), 32'(en));
        check({tag, "_err"}, 32'(bus.err), 32'(ee));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.result     = 16'h0000;
        bus.sub_result = 1'b0;
        bus.div_result = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_bcd", 32'(bus.bcd), 32'd0);
        check("rst_neg", 32'(bus.neg), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("add300", 16'd300, 1'b0, 1'b0, 20'h00300, 1'b0, 1'b0);
`ifdef CALC_BCD_SIGN_EN
        run("subneg5", 16'hFFFB, 1'b1, 1'b0, 20'h00005, 1'b1, 1'b0);
        run("sub8000", 16'h8000, 1'b1, 1'b0, 20'h32768, 1'b1, 1'b0);
        run("subneg1", 16'hFFFF, 1'b1, 1'b0, 20'h00001, 1'b1, 1'b0);
`else
        run("subneg5", 16'hFFFB, 1'b1, 1'b0, 20'h65531, 1'b0, 1'b0);
        run("sub8000", 16'h8000, 1'b1, 1'b0, 20'h32768, 1'b0, 1'b0);
        run("subneg1", 16'hFFFF, 1'b1, 1'b0, 20'h65535, 1'b0, 1'b0);
`endif
        run("sub42", 16'd42, 1'b1, 1'b0, 20'h00042, 1'b0, 1'b0);
        run("mul65025", 16'd65025, 1'b0, 1'b0, 20'h65025, 1'b0, 1'b0);
        run("divzero", 16'hFFFF, 1'b0, 1'b1, 20'hFFFFF, 1'b0, 1'b1);
        run("divFFFE", 16'hFFFE, 1'b0, 1'b1, 20'h65534, 1'b0, 1'b0);
        run("zero", 16'd0, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0);

        // Backpressure: DONE holds while new inputs are offered and ignored.
        bus.out_ready = 1'b0;
        bus.result    = 16'd7;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.result   = 16'(999 + i);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_bcd", 32'(bus.bcd), 32'h00007);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_bcd_held", 32'(bus.bcd), 32'h00007);

        // Asynchronous reset during the 8th conversion cycle.
        bus.result   = 16'd4321;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_bcd", 32'(bus.bcd), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("post_rst1234", 16'd1234, 1'b0, 1'b0, 20'h01234, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
